sync_fifo_ctrl: RTL and testbench

- Single-clock synchronous FIFO: storage array plus internal pointer, count and status logic.
- Successor to the bare addressed FIFO storage block: callers no longer supply addresses.
- Sits between CNN pipeline stages, for example conv output to pooling input, to absorb rate mismatch.
- Generalised in width and depth; adds full/empty, programmable almost-flags and occupancy count.

---
 rtl/sync_fifo_ctrl.sv | 92 +++++++++
 tb/tb_sync_fifo_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with internal pointers, occupancy count, full/empty and almost-flags.
// Optional sticky overflow/underflow ports are enabled by defining FIFO_ERR_FLAG_EN.
module sync_fifo_ctrl #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 16,
   parameter int AFULL_TH  = DEPTH - 2,
   parameter int AEMPTY_TH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       write_en,
   input  logic                       read_en,
   output logic [WIDTH-1:0]           data_out,
   output logic                       data_out_vld,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count
`ifdef FIFO_ERR_FLAG_EN
   ,
   output logic                       overflow,
   output logic                       underflow
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_acc;
   logic             rd_acc;

   // Flags decode the registered count, so accept decisions use last-edge state only.
   assign full         = (count == CW'(DEPTH));
   assign empty        = (count == '0);
   assign almost_full  = (count >= CW'(AFULL_TH));
   assign almost_empty = (count <= CW'(AEMPTY_TH));

   assign wr_acc = write_en & ~full;
   assign rd_acc = read_en & ~empty;

   always_ff @(posedge clk) begin
      if (wr_acc && !rst) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         data_out     <= '0;
         data_out_vld <= 1'b0;
      end else begin
         data_out_vld <= rd_acc;
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            data_out <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + 1'b1;
         end
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef FIFO_ERR_FLAG_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (write_en && full) begin
            overflow <= 1'b1;
         end
         if (read_en && empty) begin
            underflow <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: vector table, corner sequences and a
// randomized run compared against a queue-based reference model.
module tb_sync_fifo_ctrl;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] data_in;
   logic             write_en;
   logic             read_en;
   logic [WIDTH-1:0] data_out;
   logic             data_out_vld;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic [4:0]       count;
`ifdef FIFO_ERR_FLAG_EN
   logic             overflow;
   logic             underflow;
`endif

   sync_fifo_ctrl #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .AFULL_TH(14),
      .AEMPTY_TH(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .data_in(data_in),
      .write_en(write_en),
      .read_en(read_en),
      .data_out(data_out),
      .data_out_vld(data_out_vld),
      .full(full),
      .empty(empty),
      .almost_full(almost_full),
      .almost_empty(almost_empty),
      .count(count)
`ifdef FIFO_ERR_FLAG_EN
      ,
      .overflow(overflow),
      .underflow(underflow)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: a queue of stored words plus the last read result.
   logic [WIDTH-1:0] q[$];
   logic [WIDTH-1:0] m_dout;
   logic             m_vld;
   logic             m_ovf;
   logic             m_unf;

   typedef struct {
      logic             rst;
      logic             we;
      logic             re;
      logic [WIDTH-1:0] din;
      int               exp_count;
      logic             exp_vld;
      logic [WIDTH-1:0] exp_dout;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_model();
      int n;
      n = q.size();
      chk("count", int'(count), n);
      chk("full", int'(full), int'(n == DEPTH));
      chk("empty", int'(empty), int'(n == 0));
      chk("almost_full", int'(almost_full), int'(n >= 14));
      chk("almost_empty", int'(almost_empty), int'(n <= 2));
      chk("data_out_vld", int'(data_out_vld), int'(m_vld));
      chk("data_out", int'(data_out), int'(m_dout));
`ifdef FIFO_ERR_FLAG_EN
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("underflow", int'(underflow), int'(m_unf));
`endif
   endtask

   // Apply one cycle of inputs, advance the model and compare all outputs.
   task automatic step(input logic r, input logic we, input logic re, input logic [WIDTH-1:0] d);
      logic was_full;
      logic was_empty;
      rst      = r;
      write_en = we;
      read_en  = re;
      data_in  = d;
      @(posedge clk);
      #1;
      if (r) begin
         q.delete();
         m_vld  = 1'b0;
         m_dout = '0;
         m_ovf  = 1'b0;
         m_unf  = 1'b0;
      end else begin
         was_full  = (q.size() == DEPTH);
         was_empty = (q.size() == 0);
         if (we && was_full) m_ovf = 1'b1;
         if (re && was_empty) m_unf = 1'b1;
         m_vld = re && !was_empty;
         if (m_vld) m_dout = q.pop_front();
         if (we && !was_full) q.push_back(d);
      end
      check_model();
   endtask

   task automatic add_vec(input logic r, input logic we, input logic re, input logic [WIDTH-1:0] d,
                          input int c, input logic v, input logic [WIDTH-1:0] o);
      vec_t t;
      t.rst = r; t.we = we; t.re = re; t.din = d;
      t.exp_count = c; t.exp_vld = v; t.exp_dout = o;
      vecs.push_back(t);
   endtask

   initial begin
      rst = 1'b1; write_en = 1'b0; read_en = 1'b0; data_in = '0;
      m_dout = '0; m_vld = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

      // Reset, idle, fill 0x01..0x10, dropped 17th write, drain, extra read.
      add_vec(1, 0, 0, 8'h00, 0, 0, 8'h00);
      add_vec(0, 0, 0, 8'h00, 0, 0, 8'h00);
      for (int i = 1; i <= 16; i++) add_vec(0, 1, 0, 8'(i), i, 0, 8'h00);
      add_vec(0, 1, 0, 8'hFF, 16, 0, 8'h00);
      for (int i = 1; i <= 16; i++) add_vec(0, 0, 1, 8'h00, 16 - i, 1, 8'(i));
      add_vec(0, 0, 1, 8'h00, 0, 0, 8'h10);
      // Simultaneous at count 5, then at empty.
      for (int i = 0; i < 5; i++) add_vec(0, 1, 0, 8'(8'h21 + i), i + 1, 0, 8'h10);
      add_vec(0, 1, 1, 8'h26, 5, 1, 8'h21);
      for (int i = 0; i < 5; i++) add_vec(0, 0, 1, 8'h00, 4 - i, 1, 8'(8'h22 + i));
      add_vec(0, 1, 1, 8'h30, 1, 0, 8'h26);
      add_vec(0, 0, 1, 8'h00, 0, 1, 8'h30);

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].we, vecs[i].re, vecs[i].din);
         chk("tbl_count", int'(count), vecs[i].exp_count);
         chk("tbl_vld", int'(data_out_vld), int'(vecs[i].exp_vld));
         chk("tbl_dout", int'(data_out), int'(vecs[i].exp_dout));
      end
`ifdef FIFO_ERR_FLAG_EN
      chk("tbl_overflow", int'(overflow), 1);
      chk("tbl_underflow", int'(underflow), 1);
`endif

      // Wrap-around: 10 in, 10 out, then 12 in and 12 out.
      step(1, 0, 0, 8'h00);
      for (int i = 0; i < 10; i++) step(0, 1, 0, 8'(8'h40 + i));
      for (int i = 0; i < 10; i++) step(0, 0, 1, 8'h00);
      for (int i = 0; i < 12; i++) step(0, 1, 0, 8'(8'h80 + i));
      for (int i = 0; i < 12; i++) begin
         step(0, 0, 1, 8'h00);
         chk("wrap_dout", int'(data_out), 8'h80 + i);
      end

      // Simultaneous at full: read taken, write dropped.
      for (int i = 0; i < 16; i++) step(0, 1, 0, 8'(8'hA0 + i));
      step(0, 1, 1, 8'hEE);
      chk("full_sim_count", int'(count), 15);
      chk("full_sim_dout", int'(data_out), 8'hA0);
      for (int i = 0; i < 15; i++) step(0, 0, 1, 8'h00);
      chk("full_sim_last", int'(data_out), 8'hAF);

      // Reset at count 7 with both requests active.
      step(1, 0, 0, 8'h00);
      for (int i = 0; i < 7; i++) step(0, 1, 0, 8'(8'h60 + i));
      step(1, 1, 1, 8'h77);
      chk("rst_count", int'(count), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_vld", int'(data_out_vld), 0);
      step(0, 1, 0, 8'h55);
      step(0, 0, 1, 8'h00);
      chk("rst_newdata", int'(data_out), 8'h55);
      chk("rst_after_empty", int'(empty), 1);

      // Randomized traffic with occasional reset.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 55),
              ($urandom_range(0, 99) < 50), 8'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
